instruction_prefetch_reg: RTL and testbench

//  Parametrised successor of the SAP instruction register. Bus writes go into
//  a small prefetch queue. The control unit pops the queue into the current

---
 rtl/sap_pkg.sv | 26 ++
 rtl/sap_sync_fifo.sv | 61 ++++++
 rtl/instruction_prefetch_reg.sv | 99 +++++++++
 tb/tb_instruction_prefetch_reg.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared SAP definitions: datapath widths, opcode encodings and the operand
// extension helper used by the instruction register, ALU and MAR.
package sap_pkg;

    localparam int SAP_DATA_W   = 8;
    localparam int SAP_OPCODE_W = 4;
    localparam int SAP_OPERAND_W = SAP_DATA_W - SAP_OPCODE_W;

    typedef enum logic [SAP_OPCODE_W-1:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } sap_opcode_e;

    function automatic logic [SAP_DATA_W-1:0] sap_extend_operand(
        input logic [SAP_OPERAND_W-1:0] operand,
        input logic                     sign_ext
    );
        logic fill;
        fill = sign_ext & operand[SAP_OPERAND_W-1];
        return {{SAP_OPCODE_W{fill}}, operand};
    endfunction

endpackage

// File: rtl/sap_sync_fifo.sv
// Single-clock circular FIFO with occupancy count; the head word is visible
// combinationally on rd_data. A push is accepted when full only if a pop frees a slot.
module sap_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == CNT_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage is never reset; only words below level are ever read out.
    always_ff @(posedge clock) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_prefetch_reg.sv
// SAP instruction register with a prefetch queue in front of it: holds the
// current instruction, flags dropped pushes and drives the extended operand.
module instruction_prefetch_reg
    import sap_pkg::*;
#(
    parameter int DATA_W   = SAP_DATA_W,
    parameter int OPCODE_W = SAP_OPCODE_W,
    parameter int DEPTH    = 4,
    parameter bit SIGN_EXT = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ir_in,
    input  logic                    ir_next,
    input  logic                    flush,
    input  logic                    ir_out,
    input  logic [DATA_W-1:0]       bus_in,
    output logic [DATA_W-1:0]       q,
    output logic                    q_valid,
    output logic [OPCODE_W-1:0]     out_control,
    output logic [DATA_W-1:0]       bus_out,
    output logic                    bus_oe,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow
);

    localparam int OPERAND_W = DATA_W - OPCODE_W;

    logic [DATA_W-1:0]    head;
    logic [OPERAND_W-1:0] operand;
    logic [DATA_W-1:0]    operand_ext;

    sap_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (ir_in),
        .pop     (ir_next),
        .clear   (flush),
        .wr_data (bus_in),
        .rd_data (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    assign out_control = q[DATA_W-1 -: OPCODE_W];
    assign operand     = q[OPERAND_W-1:0];

    always_comb begin
        operand_ext = {{OPCODE_W{1'b0}}, operand};
        if (SIGN_EXT) begin
            operand_ext = {{OPCODE_W{operand[OPERAND_W-1]}}, operand};
        end
    end

    // A push into a full queue is only lost when no pop frees a slot that edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q        <= '0;
            q_valid  <= 1'b0;
            overflow <= 1'b0;
        end else if (flush) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            if (ir_in && full && !ir_next) begin
                overflow <= 1'b1;
            end
            if (ir_next) begin
                if (!empty) begin
                    q       <= head;
                    q_valid <= 1'b1;
                end else begin
                    q_valid <= 1'b0;
                end
            end
        end
    end

    // Operand stage samples q as it stood before this edge's pop or flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_out <= '0;
            bus_oe  <= 1'b0;
        end else if (ir_out) begin
            bus_out <= operand_ext;
            bus_oe  <= 1'b1;
        end else begin
            bus_out <= '0;
            bus_oe  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_reg.sv
// Directed bench for instruction_prefetch_reg; a zero-extend and a sign-extend
// instance share stimulus so both operand modes are observed together.
module tb_instruction_prefetch_reg;

    logic       clock = 1'b0;
    logic       reset;
    logic       ir_in, ir_next, flush, ir_out;
    logic [7:0] bus_in;

    logic [7:0] q, q_sx, bus_out, bus_out_sx;
    logic       q_valid, q_valid_sx, bus_oe, bus_oe_sx;
    logic [3:0] out_control, out_control_sx;
    logic       full, full_sx, empty, empty_sx, overflow, overflow_sx;
    logic [2:0] level, level_sx;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    instruction_prefetch_reg #(.DATA_W(8), .OPCODE_W(4), .DEPTH(4), .SIGN_EXT(1'b0)) dut (
        .clock(clock), .reset(reset), .ir_in(ir_in), .ir_next(ir_next),
        .flush(flush), .ir_out(ir_out), .bus_in(bus_in), .q(q), .q_valid(q_valid),
        .out_control(out_control), .bus_out(bus_out), .bus_oe(bus_oe),
        .full(full), .empty(empty), .level(level), .overflow(overflow)
    );

    instruction_prefetch_reg #(.DATA_W(8), .OPCODE_W(4), .DEPTH(4), .SIGN_EXT(1'b1)) dut_sx (
        .clock(clock), .reset(reset), .ir_in(ir_in), .ir_next(ir_next),
        .flush(flush), .ir_out(ir_out), .bus_in(bus_in), .q(q_sx), .q_valid(q_valid_sx),
        .out_control(out_control_sx), .bus_out(bus_out_sx), .bus_oe(bus_oe_sx),
        .full(full_sx), .empty(empty_sx), .level(level_sx), .overflow(overflow_sx)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Apply one cycle of inputs, then sample 1ns after the rising edge.
    task automatic tick(input logic i_in, input logic i_next, input logic i_flush,
                        input logic i_out, input logic [7:0] data);
        ir_in   = i_in;
        ir_next = i_next;
        flush   = i_flush;
        ir_out  = i_out;
        bus_in  = data;
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] data);
        tick(1'b1, 1'b0, 1'b0, 1'b0, data);
    endtask

    task automatic pop();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] fill_words [4];
        logic [7:0] ovf_words  [5];
        fill_words = '{8'h1E, 8'h2F, 8'h3A, 8'hE0};
        ovf_words  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        // Reset held while the control inputs toggle
        reset = 1'b0;
        tick(1'b1, 1'b1, 1'b0, 1'b1, 8'hAA);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 8'hAB);
        check("rst_q", q, 8'h00);
        check("rst_q_valid", q_valid, 1'b0);
        check("rst_level", level, 3'd0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_bus_oe", bus_oe, 1'b0);
        check("rst_bus_out", bus_out, 8'h00);
        reset = 1'b1;
        idle();
        check("rel_empty", empty, 1'b1);
        check("rel_level", level, 3'd0);

        // Fill and drain in order
        for (int i = 0; i < 4; i++) push(fill_words[i]);
        check("fill_full", full, 1'b1);
        check("fill_level", level, 3'd4);
        check("fill_q_valid", q_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pop();
            check($sformatf("drain_q%0d", i), q, fill_words[i]);
            check($sformatf("drain_op%0d", i), out_control, fill_words[i][7:4]);
            check($sformatf("drain_qv%0d", i), q_valid, 1'b1);
        end
        check("drain_empty", empty, 1'b1);

        // Simultaneous push and pop on a full queue
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        check("sim_full_q", q, 8'h01);
        check("sim_full_level", level, 3'd4);
        check("sim_full_ovf", overflow, 1'b0);
        pop(); check("sim_pop1", q, 8'h02);
        pop(); check("sim_pop2", q, 8'h03);
        pop(); check("sim_pop3", q, 8'h04);
        pop(); check("sim_pop4", q, 8'h55);
        check("sim_empty", empty, 1'b1);

        // Simultaneous push and pop on an empty queue: no bypass
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
        check("sim_empty_qv", q_valid, 1'b0);
        check("sim_empty_q", q, 8'h55);
        check("sim_empty_level", level, 3'd1);
        pop();
        check("sim_empty_late_q", q, 8'h77);
        check("sim_empty_late_qv", q_valid, 1'b1);

        // Operand drive, both extension modes
        push(8'h3A);
        pop();
        check("op_q", q, 8'h3A);
        check("op_q_sx", q_sx, 8'h3A);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("op_oe", bus_oe, 1'b1);
        check("op_zext", bus_out, 8'h0A);
        check("op_oe_sx", bus_oe_sx, 1'b1);
        check("op_sext", bus_out_sx, 8'hFA);
        // Operand uses q from before a same-edge pop
        push(8'h25);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check("op_prepop", bus_out, 8'h0A);
        check("op_prepop_q", q, 8'h25);
        idle();
        check("op_off_oe", bus_oe, 1'b0);
        check("op_off_out", bus_out, 8'h00);
        check("op_off_out_sx", bus_out_sx, 8'h00);

        // Overflow: fifth push dropped, flag sticky
        for (int i = 0; i < 5; i++) push(ovf_words[i]);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_level", level, 3'd4);
        pop();
        check("ovf_first", q, 8'h11);
        check("ovf_sticky", overflow, 1'b1);
        check("ovf_level3", level, 3'd3);

        // Flush discards queue and q, keeps overflow
        tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h99);
        check("fl_level", level, 3'd0);
        check("fl_empty", empty, 1'b1);
        check("fl_qv", q_valid, 1'b0);
        check("fl_q", q, 8'h00);
        check("fl_ovf", overflow, 1'b1);
        pop();
        check("fl_discard_qv", q_valid, 1'b0);

        // Asynchronous reset mid-operation
        push(8'h42); push(8'h43); pop();
        #2 reset = 1'b0;
        #1;
        check("arst_level", level, 3'd0);
        check("arst_q", q, 8'h00);
        check("arst_ovf", overflow, 1'b0);
        check("arst_qv", q_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
